vote_logger: RTL and testbench
==============================

# vote_logger

Front-end vote capture for the voting machine. It synchronises and debounces the four raw candidate buttons and accepts exactly one vote per press while in voting mode. It keeps a saturating 8-bit tally per candidate and pulses `valid_vote_casted` for each accepted vote. Its tally and pulse outputs drive the `candidateN_vote` / `valid_vote_casted` inputs of the display/LED control block.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised cycles required before a button level change is accepted. Legal range 1–255.
- `LOCKOUT_CYCLES`, default 10: cycles after an accepted vote during which all presses are ignored. Matches the LED display window. Legal range 1–255.
- `clock`  in  1: single clock. All state is on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `mode`  in  1: 0 = voting mode (presses are counted), 1 = result mode (presses are not counted).
- `button1`..`button4`  in  1 each: raw, asynchronous, active-high candidate buttons.
- `candidate1_vote`..`candidate4_vote`  out  8 each: registered tally per candidate.
- `valid_vote_casted`  out  1: registered one-cycle pulse per accepted vote.
- `vote_error`  out  1: registered one-cycle pulse when a press is rejected because more than one button rose at the same time.

## Operation
- **Per button:** a 2-flop synchroniser feeds a debouncer.
  - The debouncer holds a debounced level `db` and a counter.
  - The counter increments while the synchroniser output differs from `db` and clears when they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, `db` takes the new level and the counter clears.
- **Rise event:** `db` is 1 and its previous-cycle value was 0. Computed combinationally from `db` and a 1-cycle delayed copy.
- **FSM states:**
  - IDLE: go to READY on the next edge once all four `db` are 0.
  - READY, `mode`=1: ignore rise events and stay in READY.
  - READY, `mode`=0, exactly one rise event: increment that candidate's tally, pulse `valid_vote_casted`, go to LOCKOUT and load the lockout counter with `LOCKOUT_CYCLES`.
  - READY, `mode`=0, two or more rise events in the same cycle: no tally change, pulse `vote_error`, go to IDLE.
  - LOCKOUT: decrement the counter each cycle and ignore all rise events. When the counter reaches 0, go to IDLE. IDLE then requires every button to be released before the next vote.
- **Arithmetic:** tallies saturate at 8'hFF.
  - A vote for a saturated candidate still pulses `valid_vote_casted` and still enters LOCKOUT.
  - The tally holds at 255 and never wraps.
- **Mode changes:** a `mode` change during LOCKOUT or IDLE does not alter FSM progress. Tallies are never cleared except by reset.
- **Reset (`reset`=0, at any time, including mid-debounce or mid-lockout):**
  - All tallies 0; `valid_vote_casted` 0; `vote_error` 0.
  - FSM in IDLE; synchronisers, `db` and all counters 0.
  - The block resumes on the first edge after `reset` returns high.

## Timing
- **Vote latency:** raw button rises before edge k and stays high.
  - Synchroniser output is 1 after edge k+1.
  - `db` is 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - Tally and `valid_vote_casted` update at edge k+2+`DEBOUNCE_CYCLES`. With the default, that is 6 edges.
- **Pulse widths:** `valid_vote_casted` and `vote_error` are high for exactly one cycle per event. They are never high in the same cycle.
- **Glitch rejection:** a raw pulse or bounce whose synchronised width is shorter than `DEBOUNCE_CYCLES` cycles produces no `db` change.
- **Minimum vote spacing:**
  - The FSM is in LOCKOUT for the `LOCKOUT_CYCLES` cycles after the accept edge and in IDLE for the following cycle.
  - It is in READY one edge after that, provided all buttons are released.
  - Minimum spacing between accepted votes is therefore `LOCKOUT_CYCLES`+2 edges.
- **Late second button:** a rise one cycle after an accepted vote falls in LOCKOUT and is discarded, not queued.

## Test plan
- **Single vote:** reset, `mode`=0, raise `button2` and hold for 20 cycles, then release. Expect `candidate2_vote`=1 and `valid_vote_casted` high for exactly one cycle, 6 edges after the raw rise. Other tallies stay 0.
- **Simultaneous press:** raise `button1` and `button3` in the same cycle. Expect `vote_error` to pulse once and all tallies unchanged. After both are released, a single `button1` press gives `candidate1_vote`=1.
- **Held button and bounce:**
  - Hold `button4` for 50 cycles: expect one vote only.
  - Release, then re-press: `candidate4_vote`=2.
  - A 3-cycle raw glitch on `button1`: no vote.
- **Result mode:** with `mode`=1, press each button. Expect tallies unchanged and no pulses. Then switch to `mode`=0, press `button3`: `candidate3_vote` increments.
- **Saturation:** 256 separated presses of `button1`. Expect `candidate1_vote`=255 after the 255th and still 255 after the 256th, with `valid_vote_casted` pulsing all 256 times.
- **Reset mid-operation:** assert `reset` low for 1 cycle, asynchronously and mid-LOCKOUT, with tallies non-zero. Expect all outputs 0 immediately. The next press after release is accepted with normal latency.

Source files
------------

// File: rtl/vote_logger_if.sv
// vote_logger_if: mode/button inputs and tally/pulse outputs of the vote logger
interface vote_logger_if;
  logic       mode;
  logic       button1, button2, button3, button4;
  logic [7:0] candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote;
  logic       valid_vote_casted;
  logic       vote_error;
  modport slave (
    input  mode, button1, button2, button3, button4,
    output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
           valid_vote_casted, vote_error
  );
  modport master (
    output mode, button1, button2, button3, button4,
    input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
           valid_vote_casted, vote_error
  );
endinterface

// File: rtl/vote_logger.sv
// vote_logger: debounced one-vote-per-press capture with saturating per-candidate tallies
module vote_logger #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 10
) (
  input  logic          clock,
  input  logic          reset,
  vote_logger_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READY, LOCKOUT} state_e;
  state_e     state_q, state_d;
  logic [3:0] raw, sync1_q, sync2_q, db_q, db_d, db_prev_q, rise;
  logic [7:0] cnt_q [4], cnt_d [4];
  logic [7:0] tally_q [4], tally_d [4];
  logic [7:0] lock_q, lock_d;
  logic       valid_q, valid_d, err_q, err_d, one_hot;
  assign raw     = {bus.button4, bus.button3, bus.button2, bus.button1};
  assign rise    = db_q & ~db_prev_q;
  assign one_hot = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
  // the debounce counter only runs while the synchronised level disagrees with db
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = (sync2_q[i] != db_q[i] && cnt_q[i] + 8'd1 != 8'(DEBOUNCE_CYCLES)) ? cnt_q[i] + 8'd1 : 8'd0;
      db_d[i]  = (sync2_q[i] != db_q[i] && cnt_q[i] + 8'd1 == 8'(DEBOUNCE_CYCLES)) ? sync2_q[i] : db_q[i];
    end
  end
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    for (int i = 0; i < 4; i++) tally_d[i] = tally_q[i];
    case (state_q)
      IDLE: state_d = (db_q == 4'd0) ? READY : IDLE;
      READY: begin
        if (!bus.mode && one_hot) begin
          state_d = LOCKOUT;
          lock_d  = 8'(LOCKOUT_CYCLES);
          valid_d = 1'b1;
          for (int i = 0; i < 4; i++)
            tally_d[i] = tally_q[i] + {7'd0, rise[i] && tally_q[i] != 8'hFF};
        end else if (!bus.mode && rise != 4'd0) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      LOCKOUT: begin
        lock_d  = lock_q - 8'd1;
        state_d = (lock_q == 8'd1) ? IDLE : LOCKOUT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      lock_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]   <= '0;
        tally_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      lock_q    <= lock_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]   <= cnt_d[i];
        tally_q[i] <= tally_d[i];
      end
    end
  end
  assign bus.candidate1_vote   = tally_q[0];
  assign bus.candidate2_vote   = tally_q[1];
  assign bus.candidate3_vote   = tally_q[2];
  assign bus.candidate4_vote   = tally_q[3];
  assign bus.valid_vote_casted = valid_q;
  assign bus.vote_error        = err_q;
endmodule

// File: tb/tb_vote_logger.sv
// tb_vote_logger: directed and randomized press sequences checked against a press-level vote model
module tb_vote_logger;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vote_logger_if bus ();
  vote_logger #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(10)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  int nv = 0, ne = 0, both = 0;
  int m [4];
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_vote_casted) nv++;
      if (bus.vote_error) ne++;
      if (bus.valid_vote_casted && bus.vote_error) both++;
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int tally(input int i);
    case (i)
      0:       return int'(bus.candidate1_vote);
      1:       return int'(bus.candidate2_vote);
      2:       return int'(bus.candidate3_vote);
      default: return int'(bus.candidate4_vote);
    endcase
  endfunction
  task automatic check_tallies(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s cand%0d", tag, i + 1), tally(i), m[i]);
  endtask
  task automatic set_btn(input logic [3:0] b);
    {bus.button4, bus.button3, bus.button2, bus.button1} = b;
  endtask
  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    @(negedge clk) set_btn(mask);
    repeat (hold) @(negedge clk);
    set_btn(4'd0);
    repeat (gap) @(negedge clk);
  endtask
  // a clean press casts one vote in voting mode if exactly one button is pressed, an error if several
  task automatic press_exp(input logic [3:0] mask, input int hold, input string tag);
    int v0, e0, ev, ee;
    v0 = nv; e0 = ne; ev = 0; ee = 0;
    if (!bus.mode && $countones(mask) == 1) begin
      ev = 1;
      for (int i = 0; i < 4; i++) if (mask[i] && m[i] < 255) m[i]++;
    end else if (!bus.mode && mask != 4'd0) ee = 1;
    press(mask, hold, 22);
    chk({tag, " valid pulses"}, nv - v0, ev);
    chk({tag, " error pulses"}, ne - e0, ee);
    check_tallies(tag);
  endtask
  task automatic vote_latency(input int b, input string tag);
    int v0;
    v0 = nv;
    @(negedge clk) set_btn(4'(1 << b));
    repeat (6) @(posedge clk);
    #1 chk({tag, " valid before edge 6"}, int'(bus.valid_vote_casted), 0);
    chk({tag, " tally before edge 6"}, tally(b), m[b]);
    @(posedge clk);
    if (m[b] < 255) m[b]++;
    #1 chk({tag, " valid at edge 6"}, int'(bus.valid_vote_casted), 1);
    chk({tag, " tally at edge 6"}, tally(b), m[b]);
    @(posedge clk);
    #1 chk({tag, " valid after edge 6"}, int'(bus.valid_vote_casted), 0);
    repeat (14) @(negedge clk);
    set_btn(4'd0);
    repeat (22) @(negedge clk);
    chk({tag, " single pulse"}, nv - v0, 1);
    check_tallies(tag);
  endtask
  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int v0, e0;
    logic [3:0] mask;
    for (int i = 0; i < 4; i++) m[i] = 0;
    set_btn(4'd0);
    bus.mode = 1'b0;
    repeat (3) @(negedge clk);
    check_tallies("reset");
    chk("reset valid", int'(bus.valid_vote_casted), 0);
    chk("reset error", int'(bus.vote_error), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vote_latency(1, "single b2");
    press_exp(4'b0101, 30, "simul b1b3");
    press_exp(4'b0001, 10, "b1 after simul");
    press_exp(4'b1000, 50, "held b4");
    press_exp(4'b1000, 10, "repress b4");
    chk("cand4 two votes", tally(3), 2);
    v0 = nv;
    press(4'b0001, 3, 20);
    chk("glitch pulses", nv - v0, 0);
    check_tallies("glitch");
    bus.mode = 1'b1;
    for (int i = 0; i < 4; i++) press_exp(4'(1 << i), 10, $sformatf("result mode b%0d", i + 1));
    bus.mode = 1'b0;
    press_exp(4'b0100, 10, "voting b3");
    v0 = nv; e0 = ne;
    @(negedge clk) set_btn(4'b0001);
    repeat (8) @(negedge clk);
    set_btn(4'b0011);
    repeat (20) @(negedge clk);
    set_btn(4'b0000);
    repeat (22) @(negedge clk);
    m[0]++;
    chk("late b2 valid pulses", nv - v0, 1);
    chk("late b2 error pulses", ne - e0, 0);
    check_tallies("late b2");
    do_reset();
    v0 = nv;
    for (int n = 1; n <= 256; n++) begin
      press(4'b0001, 8, 14);
      if (n == 255) chk("sat after 255", tally(0), 255);
    end
    m[0] = 255;
    chk("sat after 256", tally(0), 255);
    chk("sat valid pulses", nv - v0, 256);
    vote_latency(1, "pre-reset b2");
    @(negedge clk) set_btn(4'b0010);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    set_btn(4'd0);
    for (int i = 0; i < 4; i++) m[i] = 0;
    #1 check_tallies("async reset");
    chk("async reset valid", int'(bus.valid_vote_casted), 0);
    chk("async reset error", int'(bus.vote_error), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vote_latency(1, "post-reset b2");
    for (int n = 0; n < 40; n++) begin
      bus.mode = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) mask = 4'(1 << $urandom_range(0, 3));
      else begin
        mask = 4'($urandom_range(0, 15));
        while ($countones(mask) < 2) mask = 4'($urandom_range(0, 15));
      end
      press_exp(mask, int'($urandom_range(8, 25)), $sformatf("rand%0d", n));
    end
    chk("valid and error overlap", both, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
